mem_line_bus_ctrl: RTL and testbench
====================================

Name: mem_line_bus_ctrl

Overview:
- Memory-side controller between the cache arbiter and the 64-bit system bus.
- Accepts one 512-bit line read or write request from the arbiter and sequences it as tagged 64-bit bus beats.
- For reads, reassembles 8 response beats into a line and pulses completion back to the arbiter.
- Decodes snoop-invalidation responses from the bus and forwards them as a one-cycle invalidate pulse with address.

Parameters:
BUS_W, 64, bus beat width in bits
LINE_W, 512, cache line width in bits (LINE_W/BUS_W = 8 beats)
TAG_W, 13, bus tag width
READ_TAG, 13'h1100, tag driven on read requests and expected on read responses
WRITE_TAG, 13'h0100, tag driven on write requests
INV_TAG, 13'h0300, response tag identifying a snoop invalidation

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
mem_address  in  64  line request address from arbiter
mem_data_out  in  512  write line from arbiter
mem_req  in  1  request strobe, sampled only in IDLE
mem_wr_en  in  1  1=write, 0=read, sampled with mem_req
data_from_mem  out  512  assembled read line
mem_data_valid  out  1  one-cycle completion pulse (read or write)
invalidate_cache  out  1  one-cycle invalidate pulse
invalidate_cache_addr  out  64  line-aligned invalidate address
busy  out  1  high in any state other than IDLE
bus_reqcyc  out  1  request beat valid
bus_req  out  64  request beat payload
bus_reqtag  out  13  request tag
bus_reqack  in  1  bus accepted current request beat
bus_respcyc  in  1  response beat valid
bus_resp  in  64  response beat payload
bus_resptag  in  13  response tag
bus_respack  out  1  response beat consumed

Behaviour:
- Reset (async, any state): state=IDLE, beat counter=0. All outputs 0, including data_from_mem and bus_reqcyc; any in-flight transaction is abandoned.
- Accept: in IDLE with mem_req=1, latch the following, then go to REQ_ADDR next cycle:
  - addr = {mem_address[63:6], 6'b0}
  - wdata = mem_data_out
  - is_wr = mem_wr_en
- mem_req outside IDLE is ignored; there is no queueing.
- REQ_ADDR: bus_reqcyc=1, bus_req=latched addr, bus_reqtag = is_wr ? WRITE_TAG : READ_TAG. Hold stable until bus_reqack. On the ack edge: write goes to REQ_DATA (counter=0); read goes to WAIT_RESP (counter=0).
- REQ_DATA: bus_reqcyc=1, bus_req = wdata[64*cnt+63 : 64*cnt], tag=WRITE_TAG. Each beat is held until bus_reqack; on ack, counter increments. When beat 7 is acked, go to DONE.
- WAIT_RESP: a beat with bus_respcyc=1 and bus_resptag=READ_TAG writes bus_resp into line slice cnt (beat 0 = bits [63:0]) and increments the counter. After beat 7, go to DONE.
- DONE (one cycle): mem_data_valid=1. For reads, data_from_mem holds the full assembled line in this cycle and keeps it until the next read completes. For writes, data_from_mem is unchanged. Next state is IDLE.
- bus_respack is combinational and equals bus_respcyc in every state except reset: every response beat is consumed the cycle it is presented.
- Invalidation: a response beat with tag INV_TAG, in any state, causes the following on the next cycle:
  - invalidate_cache=1 for one cycle
  - invalidate_cache_addr = {bus_resp[63:6], 6'b0}
  - this beat does not advance the read beat counter and is not written into the line.
- Back-to-back invalidations produce back-to-back pulses. invalidate_cache_addr holds its last value when idle.
- Stray beats: a READ_TAG beat outside WAIT_RESP, or any beat with an unknown tag, is acked and dropped with no state change.
- bus_reqcyc is 0 in IDLE, WAIT_RESP and DONE. When bus_reqcyc=0, bus_req and bus_reqtag are 0.
- Latency (no bus stalls): read = accept cycle + 1 address cycle + 8 response cycles + DONE. Write = accept cycle + 9 request cycles + DONE.
- The counter is 3 bits and is reset to 0 on every state entry into REQ_DATA or WAIT_RESP.

Test Plan:
- Read, no stalls: mem_req=1, mem_wr_en=0, mem_address=64'h8000_1234 → bus_req=64'h8000_1200 with tag 13'h1100. Respond with beats 64'h0 … 64'h7 → data_from_mem[511:448]=64'h7, [63:0]=64'h0, and mem_data_valid pulses exactly once.
- Write with reqack stalls: line with beat i = 64'hA0+i, and reqack asserted every other cycle → 9 request beats appear in order (address first) with tag 13'h0100, each held stable until acked; mem_data_valid pulses once after the 9th ack.
- Invalidation interleaved mid-read: INV_TAG beat carrying 64'h4000_0040 arrives after read beat 3 → invalidate_cache pulses with addr 64'h4000_0040, and the read still completes with all 8 correct beats.
- Request while busy: second mem_req pulses during WAIT_RESP → ignored, with no extra bus request issued; a mem_req after DONE is accepted normally.
- Reset mid-write: assert rst during REQ_DATA beat 4 → bus_reqcyc, busy and mem_data_valid are 0 immediately; after release, a new read completes normally.
- Stray response in IDLE: READ_TAG beat with respcyc=1 → bus_respack=1 that cycle, and no mem_data_valid or state change.

Source files
------------

// File: rtl/mem_line_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_line_bus_ctrl
//  Brief    : Splits 512-bit line reads/writes into tagged 64-bit bus beats,
//             reassembles read lines and forwards snoop invalidations.
//  Revision : 1.0  initial release
// ============================================================================
module mem_line_bus_ctrl #(
  parameter int              BUS_W     = 64,
  parameter int              LINE_W    = 512,
  parameter int              TAG_W     = 13,
  parameter logic [TAG_W-1:0] READ_TAG  = 13'h1100,
  parameter logic [TAG_W-1:0] WRITE_TAG = 13'h0100,
  parameter logic [TAG_W-1:0] INV_TAG   = 13'h0300
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [63:0]       mem_address,
  input  logic [LINE_W-1:0] mem_data_out,
  input  logic              mem_req,
  input  logic              mem_wr_en,
  output logic [LINE_W-1:0] data_from_mem,
  output logic              mem_data_valid,
  output logic              invalidate_cache,
  output logic [63:0]       invalidate_cache_addr,
  output logic              busy,
  output logic              bus_reqcyc,
  output logic [BUS_W-1:0]  bus_req,
  output logic [TAG_W-1:0]  bus_reqtag,
  input  logic              bus_reqack,
  input  logic              bus_respcyc,
  input  logic [BUS_W-1:0]  bus_resp,
  input  logic [TAG_W-1:0]  bus_resptag,
  output logic              bus_respack
);

  localparam int NBEATS = LINE_W / BUS_W;
  localparam int CW     = $clog2(NBEATS);
  localparam int OFS    = $clog2(LINE_W / 8);
  localparam logic [CW-1:0] C_LAST = CW'(NBEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ_ADDR  = 3'd1,
    S_REQ_DATA  = 3'd2,
    S_WAIT_RESP = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [63:0]       r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic [LINE_W-1:0] r_line;
  logic [LINE_W-1:0] r_rdata;
  logic              r_is_wr;
  logic              r_inv;
  logic [63:0]       r_inv_addr;

  logic w_resp_rd;
  logic w_resp_inv;
  logic w_unused;

  assign w_resp_rd  = bus_respcyc && (bus_resptag == READ_TAG);
  assign w_resp_inv = bus_respcyc && (bus_resptag == INV_TAG);
  assign w_unused   = &{1'b0, mem_address[OFS-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_line     <= '0;
      r_rdata    <= '0;
      r_is_wr    <= 1'b0;
      r_inv      <= 1'b0;
      r_inv_addr <= '0;
    end else begin
      // Invalidations are honoured in every state and never touch the line.
      r_inv <= w_resp_inv;
      if (w_resp_inv)
        r_inv_addr <= {bus_resp[63:OFS], {OFS{1'b0}}};

      case (r_state)
        S_IDLE: begin
          if (mem_req) begin
            r_addr  <= {mem_address[63:OFS], {OFS{1'b0}}};
            r_wdata <= mem_data_out;
            r_is_wr <= mem_wr_en;
            r_state <= S_REQ_ADDR;
          end
        end
        S_REQ_ADDR: begin
          if (bus_reqack) begin
            r_cnt   <= '0;
            r_state <= r_is_wr ? S_REQ_DATA : S_WAIT_RESP;
          end
        end
        S_REQ_DATA: begin
          if (bus_reqack) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == C_LAST)
              r_state <= S_DONE;
          end
        end
        S_WAIT_RESP: begin
          if (w_resp_rd) begin
            r_line[r_cnt*BUS_W +: BUS_W] <= bus_resp;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == C_LAST) begin
              // Publish the finished line in one step so the output never shows a partial line.
              r_rdata <= {bus_resp, r_line[LINE_W-BUS_W-1:0]};
              r_state <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus_reqcyc = 1'b0;
    bus_req    = '0;
    bus_reqtag = '0;
    if (r_state == S_REQ_ADDR) begin
      bus_reqcyc = 1'b1;
      bus_req    = r_addr;
      bus_reqtag = r_is_wr ? WRITE_TAG : READ_TAG;
    end else if (r_state == S_REQ_DATA) begin
      bus_reqcyc = 1'b1;
      bus_req    = r_wdata[r_cnt*BUS_W +: BUS_W];
      bus_reqtag = WRITE_TAG;
    end
  end

  assign data_from_mem         = r_rdata;
  assign mem_data_valid        = (r_state == S_DONE);
  assign busy                  = (r_state != S_IDLE);
  assign invalidate_cache      = r_inv;
  assign invalidate_cache_addr = r_inv_addr;
  assign bus_respack           = bus_respcyc & ~rst;

endmodule
`default_nettype wire

// File: tb/tb_mem_line_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_line_bus_ctrl
//  Brief    : Directed self-checking bench for mem_line_bus_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_line_bus_ctrl;

  localparam logic [12:0] RD  = 13'h1100;
  localparam logic [12:0] WR  = 13'h0100;
  localparam logic [12:0] INV = 13'h0300;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [63:0]  mem_address = '0;
  logic [511:0] mem_data_out = '0;
  logic         mem_req = 1'b0;
  logic         mem_wr_en = 1'b0;
  logic [511:0] data_from_mem;
  logic         mem_data_valid;
  logic         invalidate_cache;
  logic [63:0]  invalidate_cache_addr;
  logic         busy;
  logic         bus_reqcyc;
  logic [63:0]  bus_req;
  logic [12:0]  bus_reqtag;
  logic         bus_reqack = 1'b0;
  logic         bus_respcyc = 1'b0;
  logic [63:0]  bus_resp = '0;
  logic [12:0]  bus_resptag = '0;
  logic         bus_respack;

  int n_checks = 0;
  int n_fail   = 0;

  logic [511:0] line_a, line_w, line_b, line_c, line_d;

  always #5 clk = ~clk;

  mem_line_bus_ctrl dut (
    .clk                   (clk),
    .rst                   (rst),
    .mem_address           (mem_address),
    .mem_data_out          (mem_data_out),
    .mem_req               (mem_req),
    .mem_wr_en             (mem_wr_en),
    .data_from_mem         (data_from_mem),
    .mem_data_valid        (mem_data_valid),
    .invalidate_cache      (invalidate_cache),
    .invalidate_cache_addr (invalidate_cache_addr),
    .busy                  (busy),
    .bus_reqcyc            (bus_reqcyc),
    .bus_req               (bus_req),
    .bus_reqtag            (bus_reqtag),
    .bus_reqack            (bus_reqack),
    .bus_respcyc           (bus_respcyc),
    .bus_resp              (bus_resp),
    .bus_resptag           (bus_resptag),
    .bus_respack           (bus_respack)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic resp_beat(input logic [63:0] d, input logic [12:0] tag);
    bus_respcyc = 1'b1;
    bus_resp    = d;
    bus_resptag = tag;
    tick;
    bus_respcyc = 1'b0;
    bus_resp    = '0;
    bus_resptag = '0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      line_a[i*64 +: 64] = 64'(i);
      line_w[i*64 +: 64] = 64'hA0 + 64'(i);
      line_b[i*64 +: 64] = 64'h100 + 64'(i);
      line_c[i*64 +: 64] = 64'h200 + 64'(i);
      line_d[i*64 +: 64] = 64'hC0DE_0000 + 64'(i);
    end

    // Reset values
    repeat (3) tick;
    check("rst_data", data_from_mem, '0);
    check("rst_valid", mem_data_valid, 0);
    check("rst_inv", invalidate_cache, 0);
    check("rst_inv_addr", invalidate_cache_addr, '0);
    check("rst_busy", busy, 0);
    check("rst_reqcyc", bus_reqcyc, 0);
    check("rst_req", bus_req, '0);
    check("rst_reqtag", bus_reqtag, '0);
    rst = 1'b0;
    tick;

    // Read, no stalls
    mem_req = 1'b1; mem_wr_en = 1'b0; mem_address = 64'h8000_1234;
    tick;
    mem_req = 1'b0;
    check("rd_busy", busy, 1);
    check("rd_reqcyc", bus_reqcyc, 1);
    check("rd_addr", bus_req, 64'h8000_1200);
    check("rd_tag", bus_reqtag, RD);
    check("rd_valid_early", mem_data_valid, 0);
    bus_reqack = 1'b1;
    tick;
    bus_reqack = 1'b0;
    check("rd_wait_reqcyc", bus_reqcyc, 0);
    check("rd_wait_req", bus_req, '0);
    check("rd_wait_tag", bus_reqtag, '0);
    bus_respcyc = 1'b1; bus_resp = 64'h0; bus_resptag = RD;
    #1;
    check("rd_respack", bus_respack, 1);
    for (int i = 0; i < 8; i++) resp_beat(64'(i), RD);
    check("rd_valid", mem_data_valid, 1);
    check("rd_line", data_from_mem, line_a);
    check("rd_top_beat", data_from_mem[511:448], 64'h7);
    check("rd_low_beat", data_from_mem[63:0], 64'h0);
    tick;
    check("rd_valid_once", mem_data_valid, 0);
    check("rd_idle", busy, 0);

    // Write with reqack every other cycle
    mem_req = 1'b1; mem_wr_en = 1'b1; mem_address = 64'h1000_00BF; mem_data_out = line_w;
    tick;
    mem_req = 1'b0;
    for (int k = 0; k < 9; k++) begin
      logic [63:0] exp_beat;
      exp_beat = (k == 0) ? 64'h1000_0080 : 64'hA0 + 64'(k - 1);
      check($sformatf("wr_reqcyc%0d", k), bus_reqcyc, 1);
      check($sformatf("wr_beat%0d", k), bus_req, exp_beat);
      check($sformatf("wr_tag%0d", k), bus_reqtag, WR);
      check($sformatf("wr_valid%0d", k), mem_data_valid, 0);
      tick;
      check($sformatf("wr_hold%0d", k), bus_req, exp_beat);
      bus_reqack = 1'b1;
      tick;
      bus_reqack = 1'b0;
    end
    check("wr_valid", mem_data_valid, 1);
    check("wr_data_kept", data_from_mem, line_a);
    check("wr_done_reqcyc", bus_reqcyc, 0);
    tick;
    check("wr_valid_once", mem_data_valid, 0);
    check("wr_idle", busy, 0);

    // Invalidation and unknown tag interleaved mid-read
    mem_req = 1'b1; mem_wr_en = 1'b0; mem_address = 64'h2000_0047;
    tick;
    mem_req = 1'b0;
    check("inv_rd_addr", bus_req, 64'h2000_0040);
    bus_reqack = 1'b1;
    tick;
    bus_reqack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      resp_beat(64'h100 + 64'(i), RD);
      if (i == 3) begin
        resp_beat(64'h4000_0040, INV);
        check("inv_pulse", invalidate_cache, 1);
        check("inv_addr", invalidate_cache_addr, 64'h4000_0040);
        check("inv_no_done", mem_data_valid, 0);
        resp_beat(64'hDEAD_BEEF, 13'h0555);
        check("inv_pulse_end", invalidate_cache, 0);
        check("inv_addr_hold", invalidate_cache_addr, 64'h4000_0040);
      end
    end
    check("inv_rd_valid", mem_data_valid, 1);
    check("inv_rd_line", data_from_mem, line_b);
    tick;

    // Request while busy is ignored
    mem_req = 1'b1; mem_wr_en = 1'b0; mem_address = 64'h3000_0000;
    tick;
    mem_req = 1'b0;
    bus_reqack = 1'b1;
    tick;
    bus_reqack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem_req = (i == 2 || i == 3);
      mem_wr_en = 1'b1;
      resp_beat(64'h200 + 64'(i), RD);
      if (i == 3) check("busy_req_ignored", bus_reqcyc, 0);
    end
    mem_req = 1'b0;
    check("busy_rd_valid", mem_data_valid, 1);
    check("busy_rd_line", data_from_mem, line_c);
    tick;
    check("busy_no_extra_req", bus_reqcyc, 0);
    check("busy_idle", busy, 0);

    // Accepted write, then reset during data beat 4
    mem_req = 1'b1; mem_wr_en = 1'b1; mem_address = 64'h7000_0000; mem_data_out = line_w;
    tick;
    mem_req = 1'b0;
    check("post_req_accept", bus_reqcyc, 1);
    check("post_req_addr", bus_req, 64'h7000_0000);
    bus_reqack = 1'b1;
    repeat (5) tick;
    check("rstw_beat4", bus_req, 64'hA4);
    rst = 1'b1;
    bus_reqack = 1'b0;
    bus_respcyc = 1'b1; bus_resptag = RD;
    #1;
    check("rstw_reqcyc", bus_reqcyc, 0);
    check("rstw_busy", busy, 0);
    check("rstw_valid", mem_data_valid, 0);
    check("rstw_respack", bus_respack, 0);
    check("rstw_data", data_from_mem, '0);
    bus_respcyc = 1'b0; bus_resptag = '0;
    tick;
    rst = 1'b0;
    tick;
    check("rstw_idle", busy, 0);

    // Read after reset, address acked in its first cycle
    mem_req = 1'b1; mem_wr_en = 1'b0; mem_address = 64'h6000_0000_0000_0100;
    bus_reqack = 1'b1;
    tick;
    mem_req = 1'b0;
    check("rr_addr", bus_req, 64'h6000_0000_0000_0100);
    tick;
    bus_reqack = 1'b0;
    for (int i = 0; i < 8; i++) resp_beat(64'hC0DE_0000 + 64'(i), RD);
    check("rr_valid", mem_data_valid, 1);
    check("rr_line", data_from_mem, line_d);
    tick;

    // Stray read beat in IDLE
    bus_respcyc = 1'b1; bus_resptag = RD; bus_resp = 64'hFFFF;
    #1;
    check("stray_respack", bus_respack, 1);
    tick;
    bus_respcyc = 1'b0; bus_resptag = '0; bus_resp = '0;
    check("stray_busy", busy, 0);
    check("stray_valid", mem_data_valid, 0);
    check("stray_reqcyc", bus_reqcyc, 0);
    check("stray_data", data_from_mem, line_d);

    // Back-to-back invalidations
    resp_beat(64'h1111_1140, INV);
    check("b2b_inv0", invalidate_cache, 1);
    check("b2b_addr0", invalidate_cache_addr, 64'h1111_1140);
    resp_beat(64'h2222_22FF, INV);
    check("b2b_inv1", invalidate_cache, 1);
    check("b2b_addr1", invalidate_cache_addr, 64'h2222_22C0);
    tick;
    check("b2b_end", invalidate_cache, 0);
    check("b2b_hold", invalidate_cache_addr, 64'h2222_22C0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
